// File: rtl/decode_ctrl.sv
// decode_ctrl: multi-cycle instruction decoder. One instruction is accepted in IDLE and
// walked through DECODE, REGREAD, EXECUTE and WRITEBACK, one state per enabled cycle.
module decode_ctrl #(
    parameter int unsigned WB_EN = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_instr_valid,
    input  logic [15:0] i_instr,
    output logic        o_instr_ready,
    output logic [2:0]  o_selA,
    output logic [2:0]  o_selB,
    output logic [2:0]  o_selD,
    output logic        o_rf_en,
    output logic        o_rf_we,
    output logic [3:0]  o_aluop,
    output logic [15:0] o_imm,
    output logic        o_use_imm,
    output logic [2:0]  o_state,
    output logic        o_illegal
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DECODE    = 3'd1,
        REGREAD   = 3'd2,
        EXECUTE   = 3'd3,
        WRITEBACK = 3'd4
    } state_t;

    state_t      state;
    state_t      stateNext;
    logic [15:0] instrReg;
    logic        accept;

    logic [3:0]  opcode;
    logic [2:0]  fieldD;
    logic        fieldFlag;
    logic [2:0]  fieldA;
    logic [2:0]  fieldB;
    logic [7:0]  fieldImm8;
    logic        writeOp;
    logic [15:0] immNext;
    logic        useImmNext;

    assign opcode    = instrReg[15:12];
    assign fieldD    = instrReg[11:9];
    assign fieldFlag = instrReg[8];
    assign fieldA    = instrReg[7:5];
    assign fieldB    = instrReg[4:2];
    assign fieldImm8 = instrReg[7:0];

    assign o_state = state;

    always_comb begin
        writeOp = 1'b0;
        case (opcode)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
            4'h8, 4'h9, 4'hA, 4'hB: writeOp = 1'b1;
            default:                writeOp = 1'b0;
        endcase
    end

    always_comb begin
        immNext    = 16'h0000;
        useImmNext = 1'b0;
        case (opcode)
            4'h8: begin
                useImmNext = 1'b1;
                immNext    = fieldFlag ? {fieldImm8, 8'h00} : {8'h00, fieldImm8};
            end
            4'hA, 4'hB: begin
                useImmNext = 1'b1;
                immNext    = {12'h000, instrReg[3:0]};
            end
            default: begin
                useImmNext = 1'b0;
                immNext    = 16'h0000;
            end
        endcase
    end

    // Handshake: a word transfers on a rising edge where i_instr_valid and o_instr_ready
    // are both 1. Ready is offered only in IDLE with i_en=1, so valid anywhere else is ignored.
    assign accept = (state == IDLE) && i_en && i_instr_valid;

    always_comb begin
        stateNext     = state;
        o_instr_ready = 1'b0;
        o_rf_en       = 1'b0;
        o_rf_we       = 1'b0;
        o_illegal     = 1'b0;
        case (state)
            IDLE: begin
                o_instr_ready = i_en;
                if (accept) stateNext = DECODE;
            end
            DECODE: begin
                if (i_en) stateNext = REGREAD;
            end
            REGREAD: begin
                o_rf_en   = 1'b1;
                // Gated by i_en so a stalled REGREAD still yields a single pulse.
                o_illegal = i_en && (opcode == 4'hF);
                if (i_en) stateNext = EXECUTE;
            end
            EXECUTE: begin
                o_rf_en = 1'b1;
                if (i_en) stateNext = WRITEBACK;
            end
            WRITEBACK: begin
                o_rf_en = 1'b1;
                // Only the enabled WRITEBACK cycle writes; it is also the cycle that leaves.
                o_rf_we = (WB_EN != 0) && i_en && writeOp;
                if (i_en) stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            instrReg <= 16'h0000;
        end else if (accept) begin
            instrReg <= i_instr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_selA    <= 3'd0;
            o_selB    <= 3'd0;
            o_selD    <= 3'd0;
            o_aluop   <= 4'h0;
            o_imm     <= 16'h0000;
            o_use_imm <= 1'b0;
        end else if ((state == DECODE) && i_en) begin
            o_selA    <= fieldA;
            o_selB    <= fieldB;
            o_selD    <= fieldD;
            o_aluop   <= opcode;
            o_imm     <= immNext;
            o_use_imm <= useImmNext;
        end
    end

endmodule

// File: tb/tb_decode_ctrl.sv
// tb_decode_ctrl: vector table, hand-written corner sequences and random traffic for
// decode_ctrl, all compared against an instruction-level reference model.
module tb_decode_ctrl;

    localparam int unsigned WB_EN = 1;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_en;
    logic        i_instr_valid;
    logic [15:0] i_instr;
    logic        o_instr_ready;
    logic [2:0]  o_selA;
    logic [2:0]  o_selB;
    logic [2:0]  o_selD;
    logic        o_rf_en;
    logic        o_rf_we;
    logic [3:0]  o_aluop;
    logic [15:0] o_imm;
    logic        o_use_imm;
    logic [2:0]  o_state;
    logic        o_illegal;

    decode_ctrl #(.WB_EN(WB_EN)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_en          (i_en),
        .i_instr_valid (i_instr_valid),
        .i_instr       (i_instr),
        .o_instr_ready (o_instr_ready),
        .o_selA        (o_selA),
        .o_selB        (o_selB),
        .o_selD        (o_selD),
        .o_rf_en       (o_rf_en),
        .o_rf_we       (o_rf_we),
        .o_aluop       (o_aluop),
        .o_imm         (o_imm),
        .o_use_imm     (o_use_imm),
        .o_state       (o_state),
        .o_illegal     (o_illegal)
    );

    // ---------------- clock ----------------
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];

    // ---------------- reference model ----------------
    // mAge counts enabled cycles since acceptance (0 = waiting for an instruction).
    int          mAge = 0;
    logic        modelValid = 1'b0;
    logic [15:0] mInstr = 16'h0;
    logic [2:0]  mSelA = 3'd0;
    logic [2:0]  mSelB = 3'd0;
    logic [2:0]  mSelD = 3'd0;
    logic [3:0]  mAluop = 4'h0;
    logic [15:0] mImm = 16'h0;
    logic        mUseImm = 1'b0;

    function automatic bit isWrite(input logic [3:0] op);
        return (op <= 4'd6) || ((op >= 4'd8) && (op <= 4'd11));
    endfunction

    function automatic logic [15:0] refImm(input logic [15:0] w);
        int op;
        int imm8;
        op   = int'(w[15:12]);
        imm8 = int'(w[7:0]);
        if (op == 8) return w[8] ? 16'(imm8 * 256) : 16'(imm8);
        if ((op == 10) || (op == 11)) return 16'(imm8 % 16);
        return 16'h0000;
    endfunction

    always @(posedge i_clk) begin
        if (i_rst) begin
            mAge       <= 0;
            mInstr     <= 16'h0;
            mSelA      <= 3'd0;
            mSelB      <= 3'd0;
            mSelD      <= 3'd0;
            mAluop     <= 4'h0;
            mImm       <= 16'h0;
            mUseImm    <= 1'b0;
            modelValid <= 1'b1;
            exp_q.delete();
        end else if (i_en) begin
            if (mAge == 0) begin
                if (i_instr_valid) begin
                    mInstr <= i_instr;
                    mAge   <= 1;
                    if ((WB_EN != 0) && isWrite(i_instr[15:12])) exp_q.push_back(i_instr[11:9]);
                end
            end else if (mAge == 1) begin
                mSelA   <= mInstr[7:5];
                mSelB   <= mInstr[4:2];
                mSelD   <= mInstr[11:9];
                mAluop  <= mInstr[15:12];
                mImm    <= refImm(mInstr);
                mUseImm <= (mInstr[15:12] == 4'h8) || (mInstr[15:12] == 4'hA) || (mInstr[15:12] == 4'hB);
                mAge    <= 2;
            end else begin
                mAge <= (mAge + 1) % 5;
            end
        end
    end

    function automatic logic [36:0] expVec();
        logic [2:0] st;
        logic rdy, rfEn, rfWe, ill;
        st   = 3'(mAge);
        rdy  = (mAge == 0) && i_en;
        rfEn = (mAge >= 2);
        rfWe = (WB_EN != 0) && (mAge == 4) && i_en && isWrite(mInstr[15:12]);
        ill  = (mAge == 2) && i_en && (mInstr[15:12] == 4'hF);
        return {st, rdy, rfEn, rfWe, ill, mSelA, mSelB, mSelD, mAluop, mImm, mUseImm};
    endfunction

    function automatic logic [36:0] dutVec();
        return {o_state, o_instr_ready, o_rf_en, o_rf_we, o_illegal,
                o_selA, o_selB, o_selD, o_aluop, o_imm, o_use_imm};
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic setIn(input logic rst, input logic en, input logic valid, input logic [15:0] instr);
        i_rst         = rst;
        i_en          = en;
        i_instr_valid = valid;
        i_instr       = instr;
        #2;
    endtask

    task automatic stepEdge();
        logic [2:0] e;
        if (modelValid) chk("model", 64'(dutVec()), 64'(expVec()));
        if (o_rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: unexpected write selD=%0d, expected no write", o_selD);
            end else begin
                e = exp_q.pop_front();
                chk("wb_selD", 64'(o_selD), 64'(e));
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic cycle(input logic rst, input logic en, input logic valid, input logic [15:0] instr);
        setIn(rst, en, valid, instr);
        stepEdge();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] instr;
        logic [2:0]  a;
        logic [2:0]  b;
        logic [2:0]  d;
        logic [3:0]  op;
        logic [15:0] imm;
        logic        useImm;
        int          writes;
        int          illegals;
    } vec_t;

    vec_t vecs[10];

    task automatic runVector(input vec_t v, input int idx);
        int wr;
        int il;
        wr = 0;
        il = 0;
        setIn(1'b0, 1'b1, 1'b1, v.instr);
        chk($sformatf("vec%0d_ready", idx), 64'(o_instr_ready), 64'(1));
        stepEdge();
        for (int k = 1; k <= 4; k++) begin
            setIn(1'b0, 1'b1, 1'b0, 16'h0000);
            if (o_rf_we === 1'b1) wr++;
            if (o_illegal === 1'b1) il++;
            if (k == 2)
                chk($sformatf("vec%0d_fields", idx),
                    64'({o_selA, o_selB, o_selD, o_aluop, o_imm, o_use_imm}),
                    64'({v.a, v.b, v.d, v.op, v.imm, v.useImm}));
            if (k == 4) chk($sformatf("vec%0d_wb_state", idx), 64'(o_state), 64'(4));
            stepEdge();
        end
        setIn(1'b0, 1'b1, 1'b0, 16'h0000);
        chk($sformatf("vec%0d_idle_ready", idx), 64'({o_state, o_instr_ready}), 64'({3'd0, 1'b1}));
        chk($sformatf("vec%0d_writes", idx), 64'(wr), 64'(v.writes));
        chk($sformatf("vec%0d_illegal", idx), 64'(il), 64'(v.illegals));
        stepEdge();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int wr;
        int acc[$];
        logic vld;
        logic [15:0] ins;

        vecs[0] = '{16'h0A44, 3'd2, 3'd1, 3'd5, 4'h0, 16'h0000, 1'b0, 1, 0};
        vecs[1] = '{16'h87AB, 3'd5, 3'd2, 3'd3, 4'h8, 16'hAB00, 1'b1, 1, 0};
        vecs[2] = '{16'h86AB, 3'd5, 3'd2, 3'd3, 4'h8, 16'h00AB, 1'b1, 1, 0};
        vecs[3] = '{16'h7000, 3'd0, 3'd0, 3'd0, 4'h7, 16'h0000, 1'b0, 0, 0};
        vecs[4] = '{16'hF000, 3'd0, 3'd0, 3'd0, 4'hF, 16'h0000, 1'b0, 0, 1};
        vecs[5] = '{16'hA00D, 3'd0, 3'd3, 3'd0, 4'hA, 16'h000D, 1'b1, 1, 0};
        vecs[6] = '{16'hB3F7, 3'd7, 3'd5, 3'd1, 4'hB, 16'h0007, 1'b1, 1, 0};
        vecs[7] = '{16'hC123, 3'd1, 3'd0, 3'd0, 4'hC, 16'h0000, 1'b0, 0, 0};
        vecs[8] = '{16'h9E5C, 3'd2, 3'd7, 3'd7, 4'h9, 16'h0000, 1'b0, 1, 0};
        vecs[9] = '{16'h6FFF, 3'd7, 3'd7, 3'd7, 4'h6, 16'h0000, 1'b0, 1, 0};

        i_rst = 1'b1;
        i_en = 1'b1;
        i_instr_valid = 1'b1;
        i_instr = 16'hFFFF;

        // Reset wins over enable and a valid instruction.
        cycle(1'b1, 1'b1, 1'b1, 16'hFFFF);
        cycle(1'b1, 1'b1, 1'b1, 16'hFFFF);
        setIn(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("reset_state", 64'(dutVec()), 64'({3'd0, 1'b1, 33'd0}));
        stepEdge();

        // Stall in IDLE: no ready, no acceptance.
        setIn(1'b0, 1'b0, 1'b1, 16'h0A44);
        chk("idle_stall_ready", 64'(o_instr_ready), 64'(0));
        stepEdge();
        setIn(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("idle_stall_state", 64'(o_state), 64'(0));
        stepEdge();

        for (int i = 0; i < 10; i++) runVector(vecs[i], i);

        // Stall in EXECUTE and WRITEBACK, with a stray valid during the stall.
        cycle(1'b0, 1'b1, 1'b1, 16'h0A44);
        cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            setIn(1'b0, 1'b0, 1'b1, 16'h87AB);
            chk("stall_exec", 64'({o_state, o_rf_we, o_instr_ready}), 64'({3'd3, 1'b0, 1'b0}));
            stepEdge();
        end
        cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            setIn(1'b0, 1'b0, 1'b0, 16'h0000);
            chk("stall_wb", 64'({o_state, o_rf_we}), 64'({3'd4, 1'b0}));
            stepEdge();
        end
        setIn(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("stall_release_we", 64'({o_state, o_rf_we}), 64'({3'd4, 1'b1}));
        stepEdge();
        setIn(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("stall_done", 64'({o_state, o_rf_we, o_instr_ready}), 64'({3'd0, 1'b0, 1'b1}));
        stepEdge();

        // Reset during EXECUTE aborts the write.
        cycle(1'b0, 1'b1, 1'b1, 16'h0A44);
        cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        setIn(1'b1, 1'b1, 1'b0, 16'h0000);
        chk("pre_reset_exec", 64'(o_state), 64'(3));
        stepEdge();
        wr = 0;
        for (int k = 0; k < 5; k++) begin
            setIn(1'b0, 1'b1, 1'b0, 16'h0000);
            if (k == 0) chk("reset_midop", 64'(dutVec()), 64'({3'd0, 1'b1, 33'd0}));
            if (o_rf_we === 1'b1) wr++;
            stepEdge();
        end
        chk("reset_midop_nowe", 64'(wr), 64'(0));

        // Back-to-back: valid held high, second instruction queued behind the first.
        wr = 0;
        for (int c = 0; c < 12; c++) begin
            vld = (acc.size() < 2);
            ins = (acc.size() == 0) ? 16'h0A44 : 16'h87AB;
            setIn(1'b0, 1'b1, vld, ins);
            if ((o_instr_ready === 1'b1) && vld) acc.push_back(c);
            if (o_rf_we === 1'b1) wr++;
            stepEdge();
        end
        chk("b2b_accepts", 64'(acc.size()), 64'(2));
        if (acc.size() == 2) chk("b2b_gap", 64'(acc[1] - acc[0]), 64'(5));
        chk("b2b_writes", 64'(wr), 64'(2));

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 16'($urandom));
        end
        for (int c = 0; c < 8; c++) cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_ctrl.md
DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 Parameter: WB_EN, default 1, meaning 1 enables the WRITEBACK-state register write and 0 suppresses all o_rf_we pulses (bring-up aid).
REQ-002 Port: i_clk  in  1  single clock, all state on rising edge.
REQ-003 Port: i_rst  in  1  synchronous reset, active-high.
REQ-004 Port: i_en  in  1  stage enable, 0 = stall.
REQ-005 Port: i_instr_valid  in  1  upstream instruction valid.
REQ-006 Port: i_instr  in  16  instruction word.
REQ-007 Port: o_instr_ready  out  1  decoder can accept an instruction.
REQ-008 Port: o_selA / o_selB / o_selD  out  3 each  register-file read A, read B and write selects.
REQ-009 Port: o_rf_en  out  1  register-file enable.
REQ-010 Port: o_rf_we  out  1  register-file write enable.
REQ-011 Port: o_aluop  out  4  opcode to ALU.
REQ-012 Port: o_imm  out  16  immediate.
REQ-013 Port: o_use_imm  out  1  ALU B operand is o_imm.
REQ-014 Port: o_state  out  3  current FSM state.
REQ-015 Port: o_illegal  out  1  reserved-opcode pulse.

Function
REQ-016 The instruction fields SHALL be opcode [15:12], rD [11:9], flag [8], rA [7:5], rB [4:2] and imm8 [7:0].
REQ-017 The FSM SHALL have states IDLE=0, DECODE=1, REGREAD=2, EXECUTE=3 and WRITEBACK=4, with transitions only on cycles where i_en=1.
REQ-018 o_instr_ready SHALL be 1 only in IDLE; IDLE->DECODE on i_instr_valid&o_instr_ready, capturing i_instr into the internal instruction register on that edge.
REQ-019 The FSM SHALL advance unconditionally DECODE->REGREAD->EXECUTE->WRITEBACK->IDLE, one state per enabled cycle, giving 5 cycles per instruction including the acceptance cycle.
REQ-020 o_selA, o_selB, o_selD, o_aluop, o_imm and o_use_imm SHALL be registered, updated on the DECODE->REGREAD edge, and held until the next such edge.
REQ-021 o_rf_en SHALL be 1 in REGREAD, EXECUTE and WRITEBACK, else 0.
REQ-022 o_rf_we SHALL be 1 only in WRITEBACK, only when WB_EN=1, i_en=1 and the opcode is a write opcode.
REQ-023 Write opcodes SHALL be 0000-0110 and 1000-1011.
REQ-024 Opcodes 0111, 1100, 1101 and 1110 SHALL never assert o_rf_we.
REQ-025 Opcode 1111 SHALL pulse o_illegal for exactly 1 cycle in REGREAD, SHALL never assert o_rf_we, and the FSM SHALL still return to IDLE.
REQ-026 For opcode 1000 (LOAD): o_use_imm=1; o_imm={imm8,8'h00} when flag=1, else {8'h00,imm8}.
REQ-027 For opcodes 1010/1011 (shifts): o_use_imm=1 and o_imm={12'h000,i_instr[3:0]}.
REQ-028 For all other opcodes: o_use_imm=0 and o_imm=16'h0000.
REQ-029 o_aluop SHALL equal the opcode.
REQ-030 While i_en=0: state and all registered outputs SHALL hold; o_rf_we SHALL be forced 0; o_instr_ready SHALL be 0; no instruction is accepted.
REQ-031 i_instr_valid outside IDLE SHALL be ignored, with no capture and no state change.
REQ-032 A stall in WRITEBACK SHALL produce exactly one o_rf_we cycle, on the first enabled WRITEBACK cycle.

Reset
REQ-033 When i_rst=1 at a rising edge: state=IDLE; o_selA/B/D=0; o_aluop=0; o_imm=0; o_use_imm=0; o_rf_en=0; o_rf_we=0; o_illegal=0; instruction register=0.
REQ-034 Reset SHALL take priority over i_en and i_instr_valid.
REQ-035 Reset asserted mid-instruction SHALL abort the instruction with no o_rf_we pulse after the reset edge.
REQ-036 o_instr_ready SHALL be 1 on the first cycle after reset deasserts (with i_en=1).

Verification
REQ-037 ADD: i_instr=16'h0A44 (op 0, rD=5, rA=2, rB=1), i_en=1 -> selA=2, selB=1, selD=5, aluop=0, use_imm=0; o_rf_we high for exactly 1 cycle, 4 cycles after acceptance; ready again the following cycle.
REQ-038 LOAD high byte: i_instr=16'h87AB (rD=3, flag=1) -> o_imm=16'hAB00, use_imm=1, selD=3, one o_rf_we pulse.
REQ-039 Store and illegal: 16'h7000 -> no o_rf_we; 16'hF000 -> o_illegal 1-cycle pulse in REGREAD, no o_rf_we, back to IDLE.
REQ-040 Stall: i_en=0 for 3 cycles during EXECUTE and WRITEBACK -> o_state frozen, o_rf_we=0 throughout the stall, exactly one o_rf_we after re-enable.
REQ-041 Reset mid-op: i_rst=1 during EXECUTE -> next cycle all outputs 0, state=IDLE, no write pulse.
REQ-042 Back-to-back: i_instr_valid held high with two queued instructions -> second accepted exactly 5 cycles after the first, none dropped or duplicated.
